preamble_sync: RTL and testbench
================================

Name: preamble_sync

Overview:
- Receive-side counterpart of the preamble inserter. Consumes a 32-bit valid/ready word stream of repeating frames, each being preamble_length copies of preamble_value followed by frame_length payload words.
- Hunts for the preamble, locks, strips the preamble words and forwards only payload, marking the last payload word of each frame.
- Re-checks the preamble on every frame and drops lock on mismatch.
- Sits between the channel/RX front end and the payload consumer.

Parameters:
- DATA_W, 32, stream word width.
- CNT_W, 16, width of length inputs and internal counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- preamble_value  in  DATA_W  expected preamble word.
- preamble_length  in  CNT_W  number of preamble words per frame.
- frame_length  in  CNT_W  number of payload words per frame.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid & s_ready.
- s_data  in  DATA_W  input word.
- m_valid  out  1  output payload word valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_W  output payload word.
- m_last  out  1  high with the final payload word of a frame.
- locked  out  1  high while frame alignment is held.
- sync_err  out  1  one-cycle pulse when a locked frame's preamble check fails.
- cfg_err  out  1  high while preamble_length==0 or frame_length==0.

Behaviour:
- Reset (rst==0 at a clk edge): state HUNT, counters 0; s_ready, m_valid, m_data, m_last, locked, sync_err, cfg_err all 0.
- Lengths are static during operation. They are compared live; changing them while locked is undefined.
- cfg_err is registered: cfg_err <= (preamble_length==0 || frame_length==0). While it is set, the FSM is held in HUNT, s_ready=1, all input is discarded, and locked=0.
- Accept event A = s_valid & s_ready. All state and counter updates occur only on A, except output-register drain.
- HUNT: s_ready=1, words are discarded.
  - On A with s_data==preamble_value: pcnt++.
  - On A with a mismatch: pcnt<=0.
  - When a match makes pcnt reach preamble_length: go to PAYLOAD, set locked<=1, dcnt<=0.
- PAYLOAD: s_ready = !m_valid | m_ready (one-deep output register).
  - On A: load m_data<=s_data, m_valid<=1, m_last<=(dcnt==frame_length-1), dcnt++.
  - After the last word, go to CHECK with pcnt<=0.
  - Payload words equal to preamble_value are forwarded as data; no detection is done in PAYLOAD.
- CHECK: s_ready=1, words are discarded.
  - On A with a match: pcnt++. On reaching preamble_length, go to PAYLOAD.
  - On A with a mismatch: pulse sync_err for one cycle, locked<=0, go to HUNT with pcnt<=0. The mismatching word is not counted as a preamble start.
- Output register:
  - m_valid clears on m_ready when no new word is loaded in the same cycle.
  - m_data/m_last are held stable while m_valid & !m_ready.
  - A simultaneous drain and load keeps m_valid=1 with the new word (full throughput, 1 word/cycle).
- Latency: a payload word accepted at edge N appears on m_data after edge N, and is visible in cycle N+1.
- Preamble words never appear on the m_* interface.
- Extra preamble words in HUNT beyond preamble_length are treated as payload.
- Reset mid-frame: the output word in flight is dropped (m_valid=0), and the FSM re-hunts.
- When the FSM leaves PAYLOAD with m_valid still high, the output register continues to drain normally.
- Counters are CNT_W wide. Comparisons use length-1 on nonzero lengths only, so there is no wrap.

Decomposition:
- Package preamble_pkg holds:
  - the state encoding (HUNT, PAYLOAD, CHECK);
  - DATA_W_DEFAULT=32 and CNT_W_DEFAULT=16;
  - a shared PREAMBLE_DEFAULT constant for the inserter/sync pair.
- One sub-module: axis_out_reg, a one-deep valid/ready output register carrying data+last, exposing load/can_load.

Test Plan:
- preamble_value=0xA5A5A5A5, preamble_length=3, frame_length=4; stream 3×A5A5A5A5, D0..D3, 3×A5A5A5A5, D4..D7 with m_ready=1 -> m_data D0..D7 back-to-back, m_last on D3 and D7, locked high after the 3rd preamble word, no sync_err.
- Same config; 2×A5A5A5A5, 0x1, 3×A5A5A5A5, D0..D3 -> first partial preamble rejected, output D0..D3 only, m_last on D3.
- Locked; second frame preamble is A5A5A5A5, 0xDEAD, A5A5A5A5 -> sync_err one pulse on the 0xDEAD accept, locked falls, next 3×A5A5A5A5+4 words relock and forward.
- m_ready toggled 1,0,0,1 during payload -> m_data held stable while stalled, s_ready low when the register is full and m_ready=0, no word lost or duplicated.
- Payload word equal to 0xA5A5A5A5 inside the frame -> forwarded as data, frame boundary unchanged.
- preamble_length=0 -> cfg_err=1, s_ready=1, m_valid stays 0. Assert rst=0 mid-payload -> next cycle all outputs 0 and the FSM is in HUNT.

Source files
------------

// File: rtl/preamble_pkg.sv
// Shared definitions for the preamble inserter/sync pair.
package preamble_pkg;
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  localparam int DATA_W_DEFAULT = 32;
  localparam int CNT_W_DEFAULT  = 16;
  localparam logic [31:0] PREAMBLE_DEFAULT = 32'hA5A5_A5A5;
endpackage

// File: rtl/preamble_sync_if.sv
// Input and output word streams of the preamble synchroniser.
interface preamble_sync_if #(parameter int DATA_W = 32);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport slave  (input  s_valid, s_data, m_ready,
                  output s_ready, m_valid, m_data, m_last);
  modport master (output s_valid, s_data, m_ready,
                  input  s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/preamble_sync_axis_out_reg.sv
// One-deep valid/ready output register carrying data and last.
module axis_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              can_load,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);
  assign can_load = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= ld_data;
      m_last  <= ld_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/preamble_sync.sv
// Hunts for the frame preamble, strips it, forwards payload with last marking
// and re-checks alignment on every frame.
module preamble_sync
  import preamble_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] preamble_value,
  input  logic [CNT_W-1:0]  preamble_length,
  input  logic [CNT_W-1:0]  frame_length,
  preamble_sync_if.slave    bus,
  output logic              locked,
  output logic              sync_err,
  output logic              cfg_err
);
  state_t            st, nxt;
  logic [CNT_W-1:0]  pcnt, pcnt_n, dcnt, dcnt_n;
  logic              locked_n, sync_err_n;
  logic              acc, match, p_done, d_last, load, can_load;
  logic [CNT_W-1:0]  plen_m1, flen_m1;

  assign plen_m1 = preamble_length - CNT_W'(1);
  assign flen_m1 = frame_length - CNT_W'(1);
  assign match   = (bus.s_data == preamble_value);
  assign p_done  = (pcnt == plen_m1);
  assign d_last  = (dcnt == flen_m1);

  // Ready is forced low during reset so nothing is taken before state is sane.
  always_comb begin
    bus.s_ready = 1'b0;
    if (rst) bus.s_ready = (cfg_err || st != PAYLOAD) ? 1'b1 : can_load;
  end
  assign acc = bus.s_valid && bus.s_ready;

  always_comb begin
    nxt        = st;
    pcnt_n     = pcnt;
    dcnt_n     = dcnt;
    locked_n   = locked;
    sync_err_n = 1'b0;
    load       = 1'b0;
    if (cfg_err) begin
      nxt      = HUNT;
      pcnt_n   = '0;
      dcnt_n   = '0;
      locked_n = 1'b0;
    end else if (acc) begin
      case (st)
        HUNT, CHECK: begin
          if (match) begin
            if (p_done) begin
              nxt      = PAYLOAD;
              locked_n = 1'b1;
              pcnt_n   = '0;
              dcnt_n   = '0;
            end else begin
              pcnt_n = pcnt + CNT_W'(1);
            end
          end else begin
            pcnt_n = '0;
            // A bad preamble on a locked frame drops alignment entirely.
            if (st == CHECK) begin
              nxt        = HUNT;
              sync_err_n = 1'b1;
              locked_n   = 1'b0;
            end
          end
        end
        PAYLOAD: begin
          load   = 1'b1;
          dcnt_n = dcnt + CNT_W'(1);
          if (d_last) begin
            nxt    = CHECK;
            pcnt_n = '0;
            dcnt_n = '0;
          end
        end
        default: nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st       <= HUNT;
      pcnt     <= '0;
      dcnt     <= '0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      st       <= nxt;
      pcnt     <= pcnt_n;
      dcnt     <= dcnt_n;
      locked   <= locked_n;
      sync_err <= sync_err_n;
      cfg_err  <= (preamble_length == '0) || (frame_length == '0);
    end
  end

  axis_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .ld_data  (bus.s_data),
    .ld_last  (d_last),
    .can_load (can_load),
    .m_ready  (bus.m_ready),
    .m_valid  (bus.m_valid),
    .m_data   (bus.m_data),
    .m_last   (bus.m_last)
  );
endmodule

// File: tb/tb_preamble_sync.sv
// Directed bench for preamble_sync: framing, resync, stalls, config and reset.
module tb_preamble_sync;
  import preamble_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] preamble_value  = PREAMBLE_DEFAULT;
  logic [15:0] preamble_length = 16'd3;
  logic [15:0] frame_length    = 16'd4;
  logic        locked, sync_err, cfg_err;

  int checks = 0, failures = 0, serr_cnt = 0;
  logic [32:0] got[$];
  logic [32:0] e[$];

  preamble_sync_if #(.DATA_W(32)) bus ();

  preamble_sync dut (
    .clk             (clk),
    .rst             (rst),
    .preamble_value  (preamble_value),
    .preamble_length (preamble_length),
    .frame_length    (frame_length),
    .bus             (bus.slave),
    .locked          (locked),
    .sync_err        (sync_err),
    .cfg_err         (cfg_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && bus.m_valid && bus.m_ready) got.push_back({bus.m_last, bus.m_data});
    if (sync_err) serr_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] g, input logic [63:0] x);
    checks++;
    if (g !== x) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, g, x);
    end
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    @(negedge clk);
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) chk("send_tmo", bus.s_ready, 1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic preamble3();
    repeat (3) send(32'hA5A5_A5A5);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag);
    chk({tag, "_cnt"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++) chk(tag, got[i], e[i]);
    got.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data",  bus.m_data, 0);
    chk("rst_m_last",  bus.m_last, 0);
    chk("rst_locked",  locked, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_cfg_err", cfg_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // two clean frames, back to back
    send(32'hA5A5_A5A5); send(32'hA5A5_A5A5);
    chk("s1_prelock", locked, 0);
    send(32'hA5A5_A5A5);
    chk("s1_lock", locked, 1);
    for (int i = 0; i < 4; i++) send(32'hD0 + i);
    preamble3();
    for (int i = 4; i < 8; i++) send(32'hD0 + i);
    idle(3);
    e = '{};
    for (int i = 0; i < 8; i++) e.push_back({(i == 3 || i == 7), 32'hD0 + i});
    expect_out("s1_out");
    chk("s1_serr", serr_cnt, 0);

    // partial preamble rejected
    do_reset();
    send(32'hA5A5_A5A5); send(32'hA5A5_A5A5); send(32'h1);
    chk("s2_nolock", locked, 0);
    preamble3();
    for (int i = 0; i < 4; i++) send(32'hD0 + i);
    idle(3);
    e = '{};
    for (int i = 0; i < 4; i++) e.push_back({(i == 3), 32'hD0 + i});
    expect_out("s2_out");

    // broken preamble on a locked frame, then relock
    send(32'hA5A5_A5A5); send(32'hDEAD);
    chk("s3_unlock", locked, 0);
    send(32'hA5A5_A5A5); send(32'hA5A5_A5A5); send(32'hA5A5_A5A5);
    chk("s3_relock", locked, 1);
    for (int i = 0; i < 4; i++) send(32'hE0 + i);
    idle(3);
    e = '{};
    for (int i = 0; i < 4; i++) e.push_back({(i == 3), 32'hE0 + i});
    expect_out("s3_out");
    chk("s3_serr", serr_cnt, 1);

    // downstream stall
    preamble3();
    send(32'hF0);
    bus.m_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("s4_s_ready", bus.s_ready, 0);
      chk("s4_hold", {bus.m_valid, bus.m_data}, {1'b1, 32'hF0});
      @(posedge clk); #1;
    end
    bus.m_ready = 1'b1;
    for (int i = 1; i < 4; i++) send(32'hF0 + i);
    idle(3);
    e = '{};
    for (int i = 0; i < 4; i++) e.push_back({(i == 3), 32'hF0 + i});
    expect_out("s4_out");

    // preamble-valued payload word is plain data
    preamble3();
    send(32'hC0); send(32'hA5A5_A5A5); send(32'hC2); send(32'hC3);
    preamble3();
    send(32'hC4);
    idle(3);
    e = '{ {1'b0, 32'hC0}, {1'b0, 32'hA5A5_A5A5}, {1'b0, 32'hC2}, {1'b1, 32'hC3}, {1'b0, 32'hC4} };
    expect_out("s5_out");
    chk("s5_serr", serr_cnt, 1);

    // zero preamble length
    do_reset();
    preamble_length = 16'd0;
    idle(2);
    @(negedge clk);
    chk("s6_cfg_err", cfg_err, 1);
    chk("s6_s_ready", bus.s_ready, 1);
    send(32'hA5A5_A5A5); send(32'h1); send(32'h2);
    idle(2);
    chk("s6_m_valid", bus.m_valid, 0);
    chk("s6_locked", locked, 0);
    e = '{};
    expect_out("s6_out");
    preamble_length = 16'd3;
    idle(2);
    chk("s6_cfg_clr", cfg_err, 0);

    // reset mid-payload, then re-hunt
    preamble3();
    send(32'hB0); send(32'hB1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("s7_m_valid", bus.m_valid, 0);
    chk("s7_m_data",  bus.m_data, 0);
    chk("s7_locked",  locked, 0);
    chk("s7_s_ready", bus.s_ready, 0);
    rst = 1'b1;
    got.delete();
    send(32'hB2);
    preamble3();
    for (int i = 0; i < 4; i++) send(32'h70 + i);
    idle(3);
    e = '{};
    for (int i = 0; i < 4; i++) e.push_back({(i == 3), 32'h70 + i});
    expect_out("s7_out");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
